// File: rtl/lane_packer_pkg.sv
// Shared definitions for the lane packer and the adder-tree blocks it feeds.
// Holds the default geometry and the packer state encoding.
package lane_packer_pkg;

    localparam int unsigned DefDataWidth = 12;
    localparam int unsigned DefLanes     = 4;

    typedef enum logic {
        StFill = 1'b0,
        StFull = 1'b1
    } pack_state_e;

endpackage

// File: rtl/lane_packer.sv
// Packs a serial sample stream into LANES-wide words, lane 0 first.
// An early i_last closes a group and zero-fills the unused upper lanes.
module lane_packer
    import lane_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned LANES      = DefLanes
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic [DATA_WIDTH-1:0]               i_data,
    input  logic                                i_last,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic [LANES*DATA_WIDTH-1:0]         o_data,
    output logic [$clog2(LANES):0]              o_lanes
);

    localparam int unsigned CntW  = $clog2(LANES);
    localparam int unsigned LaneW = CntW + 1;
    localparam int unsigned WordW = LANES * DATA_WIDTH;

    pack_state_e      state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WordW-1:0] fill_q;
    logic [WordW-1:0] out_data_q;
    logic [LaneW-1:0] out_lanes_q;
    logic             out_valid_q;

    logic [WordW-1:0] merged;
    logic [LaneW-1:0] closed_lanes;
    logic             in_beat;
    logic             out_free;
    logic             closing;

    // Lanes above cnt_q are always zero in fill_q, so an early close needs no explicit padding.
    always_comb begin
        merged = fill_q;
        merged[int'(cnt_q) * int'(DATA_WIDTH) +: DATA_WIDTH] = i_data;
    end

    assign o_ready      = (state_q == StFill);
    assign in_beat      = i_valid && o_ready;
    assign out_free     = !out_valid_q || i_ready;
    assign closing      = (cnt_q == CntW'(LANES - 1)) || i_last;
    assign closed_lanes = LaneW'(cnt_q) + LaneW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StFill;
            cnt_q       <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_lanes_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && i_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                StFill: begin
                    if (in_beat) begin
                        if (closing && out_free) begin
                            out_data_q  <= merged;
                            out_lanes_q <= closed_lanes;
                            out_valid_q <= 1'b1;
                            fill_q      <= '0;
                            cnt_q       <= '0;
                        end else if (closing) begin
                            // cnt_q keeps the closing lane index so the lane count survives the stall
                            fill_q  <= merged;
                            state_q <= StFull;
                        end else begin
                            fill_q <= merged;
                            cnt_q  <= cnt_q + 1'b1;
                        end
                    end
                end
                StFull: begin
                    if (out_free) begin
                        out_data_q  <= fill_q;
                        out_lanes_q <= closed_lanes;
                        out_valid_q <= 1'b1;
                        fill_q      <= '0;
                        cnt_q       <= '0;
                        state_q     <= StFill;
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

    assign o_valid = out_valid_q;
    assign o_data  = out_data_q;
    assign o_lanes = out_lanes_q;

endmodule

// File: tb/tb_lane_packer.sv
// Self-checking bench for lane_packer: directed cases plus a random valid/ready run
// scored against a queue-based model of groups and pending words.
module tb_lane_packer;
    import lane_packer_pkg::*;

    localparam int DW = DefDataWidth;
    localparam int LN = DefLanes;
    localparam int WW = DW * LN;
    localparam int LW = $clog2(LN) + 1;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          i_last;
    logic          o_valid;
    logic          i_ready;
    logic [WW-1:0] o_data;
    logic [LW-1:0] o_lanes;

    lane_packer #(
        .DATA_WIDTH (DW),
        .LANES      (LN)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_lanes (o_lanes)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  lanes;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] grp[$];
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive after the edge, observe at the falling edge, update the model.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
        word_t w;
        @(posedge i_clk);
        #1;
        i_valid = v;
        i_data  = d;
        i_last  = l;
        i_ready = r;
        @(negedge i_clk);
        check_eq("o_valid", 64'(o_valid), 64'(exp_q.size() != 0));
        check_eq("o_ready", 64'(o_ready), 64'(exp_q.size() < 2));
        if (o_valid && exp_q.size() != 0) begin
            check_eq("o_data", 64'(o_data), exp_q[0].data);
            check_eq("o_lanes", 64'(o_lanes), 64'(exp_q[0].lanes));
            if (i_ready) void'(exp_q.pop_front());
        end
        if (i_valid && o_ready) begin
            grp.push_back(i_data);
            if (i_last || grp.size() == LN) begin
                w.data = '0;
                foreach (grp[k]) w.data |= 64'(grp[k]) << (k * DW);
                w.lanes = 8'(grp.size());
                exp_q.push_back(w);
                grp.delete();
            end
        end
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #2;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check_eq("rst_o_valid", 64'(o_valid), 64'd0);
        check_eq("rst_o_data", 64'(o_data), 64'd0);
        check_eq("rst_o_lanes", 64'(o_lanes), 64'd0);
        exp_q.delete();
        grp.delete();
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_eq("post_rst_o_ready", 64'(o_ready), 64'd1);
        check_eq("post_rst_o_valid", 64'(o_valid), 64'd0);
    endtask

    initial begin
        int accepted;
        int cycles;
        logic v, l, r;
        logic [DW-1:0] d;

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;
        i_ready = 1'b0;
        do_reset();

        // Full-rate packing
        step(1'b1, 12'h001, 1'b0, 1'b1);
        step(1'b1, 12'h002, 1'b0, 1'b1);
        step(1'b1, 12'h003, 1'b0, 1'b1);
        step(1'b1, 12'h004, 1'b0, 1'b1);
        step(1'b0, 12'h000, 1'b0, 1'b1);
        check_eq("full_valid", 64'(o_valid), 64'd1);
        check_eq("full_data", 64'(o_data), 64'h004003002001);
        check_eq("full_lanes", 64'(o_lanes), 64'd4);

        // Early last, next sample lands in lane 0
        step(1'b1, 12'hABC, 1'b0, 1'b1);
        step(1'b1, 12'h123, 1'b1, 1'b1);
        step(1'b1, 12'h555, 1'b1, 1'b1);
        check_eq("last_data", 64'(o_data), 64'h000000123ABC);
        check_eq("last_lanes", 64'(o_lanes), 64'd2);
        step(1'b0, 12'h000, 1'b0, 1'b1);
        check_eq("lane0_data", 64'(o_data), 64'h000000000555);
        check_eq("lane0_lanes", 64'(o_lanes), 64'd1);
        step(1'b0, 12'h000, 1'b0, 1'b1);

        // Backpressure: second group waits in FULL
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i < 4) ? DW'(12'h011 + i) : DW'(12'h021 + i - 4), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 12'h0EE, 1'b0, 1'b0);
            check_eq("bp_ready", 64'(o_ready), 64'd0);
            check_eq("bp_hold", 64'(o_data), 64'h014013012011);
        end
        step(1'b0, 12'h000, 1'b0, 1'b1);
        check_eq("bp_first", 64'(o_data), 64'h014013012011);
        step(1'b0, 12'h000, 1'b0, 1'b1);
        check_eq("bp_second", 64'(o_data), 64'h024023022021);
        check_eq("bp_second_lanes", 64'(o_lanes), 64'd4);
        step(1'b0, 12'h000, 1'b0, 1'b1);
        check_eq("bp_drained", 64'(exp_q.size()), 64'd0);

        // Closing in-beat coincident with out-beat
        step(1'b1, 12'h101, 1'b1, 1'b1);
        step(1'b1, 12'h102, 1'b1, 1'b1);
        check_eq("sim_d1", 64'(o_data), 64'h000000000101);
        step(1'b1, 12'h103, 1'b1, 1'b1);
        check_eq("sim_v2", 64'(o_valid), 64'd1);
        check_eq("sim_d2", 64'(o_data), 64'h000000000102);
        step(1'b0, 12'h000, 1'b0, 1'b1);
        check_eq("sim_v3", 64'(o_valid), 64'd1);
        check_eq("sim_d3", 64'(o_data), 64'h000000000103);
        step(1'b0, 12'h000, 1'b0, 1'b1);

        // Reset mid-group discards the partial group
        step(1'b1, 12'h0F1, 1'b0, 1'b1);
        step(1'b1, 12'h0F2, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, DW'(12'h00A + i), 1'b0, 1'b1);
        step(1'b0, 12'h000, 1'b0, 1'b1);
        check_eq("rst_grp_data", 64'(o_data), 64'h00D00C00B00A);
        check_eq("rst_grp_lanes", 64'(o_lanes), 64'd4);
        step(1'b0, 12'h000, 1'b0, 1'b1);

        // Random valid/ready
        accepted = 0;
        cycles   = 0;
        while (accepted < 10000 && cycles < 80000) begin
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 9) < 6);
            d = DW'($urandom);
            step(v, d, l, r);
            if (i_valid && o_ready) accepted++;
            cycles++;
        end
        check_eq("rand_count", 64'(accepted >= 10000), 64'd1);
        for (int i = 0; i < 20; i++) begin
            step(grp.size() != 0, DW'($urandom), 1'b1, 1'b1);
        end
        check_eq("rand_words_left", 64'(exp_q.size()), 64'd0);
        check_eq("rand_grp_left", 64'(grp.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lane_packer.md
LANE_PACKER -- requirements
Module: lane_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, meaning the width of one sample/lane.
REQ-002 SHALL have parameter LANES, default 4, meaning the number of lanes per packed word (power of two, >=2).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port i_valid, input, 1 bit: upstream sample valid.
REQ-006 SHALL have port o_ready, output, 1 bit: packer can accept a sample this cycle.
REQ-007 SHALL have port i_data, input, DATA_WIDTH bits: serial sample.
REQ-008 SHALL have port i_last, input, 1 bit: sample closes the current group early.
REQ-009 SHALL have port o_valid, output, 1 bit: packed word valid.
REQ-010 SHALL have port i_ready, input, 1 bit: downstream (adder-tree input stage) accepts the word.
REQ-011 SHALL have port o_data, output, LANES*DATA_WIDTH bits: packed word, lane k in bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
REQ-012 SHALL have port o_lanes, output, clog2(LANES)+1 bits: count of real (non-padded) lanes in o_data.

Function
REQ-013 SHALL accept a sample when i_valid && o_ready (the "in-beat"), and SHALL emit a word when o_valid && i_ready (the "out-beat").
REQ-014 SHALL write the n-th accepted sample of a group into lane n, with lane 0 holding the first sample.
REQ-015 SHALL maintain a fill register, a lane counter cnt (0..LANES-1), and a state machine with states FILL and FULL.
REQ-016 SHALL close a group on an in-beat that has cnt==LANES-1 or i_last==1.
REQ-017 SHALL zero-fill all lanes above the closing lane of a group closed by i_last.
REQ-018 SHALL set the word's o_lanes to (index of the closing lane)+1.
REQ-019 SHALL define "output free" as !o_valid || i_ready.
REQ-020 SHALL, on a closing in-beat while output is free, load the closed group into the output register at that edge, set o_valid=1 the next cycle, and set cnt=0 with the state remaining FILL; latency from last-lane accept to o_valid is 1 cycle.
REQ-021 SHALL, on a closing in-beat while output is not free, keep the group in the fill register and move to state FULL.
REQ-022 SHALL drive o_ready=1 in state FILL and o_ready=0 in state FULL; o_ready SHALL NOT depend combinationally on i_valid.
REQ-023 SHALL, in state FULL, transfer the group to the output register on the first edge where output is free, then return to FILL with cnt=0.
REQ-024 SHALL hold o_data and o_lanes stable while o_valid && !i_ready.
REQ-025 SHALL clear o_valid on an out-beat unless a new group is loaded at the same edge.
REQ-026 SHALL sustain one sample per cycle with no bubbles while i_ready is held at 1.
REQ-027 SHALL treat i_last on the lane LANES-1 sample identically to a normal full close.

Reset
REQ-028 SHALL, while i_rst_n==0, asynchronously force o_valid=0, o_data=0, o_lanes=0, cnt=0, fill register=0, and state=FILL.
REQ-029 SHALL drive o_ready=1 in the first cycle after reset release.
REQ-030 SHALL discard any partial group and any pending output word on reset mid-operation, with no word emitted for them.

Structure
REQ-031 SHALL take DATA_WIDTH/LANES defaults and the state encoding (FILL=0, FULL=1) from the shared package used by the adder-tree blocks.
REQ-032 SHALL be a single flat module with no sub-modules; o_data SHALL be directly connectable to the i_data port of a matching AdderTree instance.

Verification
REQ-033 SHALL verify full-rate packing: samples 0x001,0x002,0x003,0x004 on consecutive cycles with i_ready=1 -> o_data=0x004003002001 and o_lanes=4, one cycle after 0x004 is accepted.
REQ-034 SHALL verify the early-last case: 0xABC, then 0x123 with i_last=1 -> o_data=0x000000123ABC, o_lanes=2, with the next sample landing in lane 0.
REQ-035 SHALL verify backpressure: i_ready=0 with a word pending while a second group of 4 arrives -> FULL state, o_ready=0, first word held stable; raising i_ready -> the two words appear in order and nothing is lost.
REQ-036 SHALL verify simultaneous events: a closing in-beat in the same cycle as an out-beat -> new word appears next cycle, o_valid stays high, no bubble.
REQ-037 SHALL verify reset mid-group: after 2 samples, pulse i_rst_n low -> all outputs 0; the next 4 samples 0x00A..0x00D -> o_data=0x00D00C00B00A.
REQ-038 SHALL verify random valid/ready over 10k samples against a scoreboard model, checking order, zero-padding, o_lanes, and stability under stall.
